conv_mdc_out_collector: RTL and testbench

CONV_MDC_OUT_COLLECTOR -- requirements
Module: conv_mdc_out_collector

---
 rtl/conv_mdc_out_collector.sv | 129 ++++++++++++
 tb/tb_conv_mdc_out_collector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_mdc_out_collector.sv
// Output collector for the MDC conv kernel: tags each beat with a frame-last flag,
// tracks the input position and buffers beats in a small FWFT FIFO towards the streamer.
module conv_mdc_out_collector #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [31:0]           width_i,
   input  logic [31:0]           height_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  out_last_o,
   output logic                  line_done_o,
   output logic                  frame_done_o,
   output logic                  busy_o,
   output logic [31:0]           col_o,
   output logic [31:0]           row_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state, state_nxt;
   logic [31:0]           width_q, height_q, col, row;
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic                  mem_last [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  full, empty, push, pop;
   logic                  col_end, row_end, beat_last, line_done;

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign col_end   = (col == width_q - 32'd1);
   assign row_end   = (row == height_q - 32'd1);
   assign beat_last = col_end && row_end;
   assign push      = in_valid_i && in_ready_o;
   assign pop       = out_valid_o && out_ready_i;

   // Handshake outputs depend only on registered state, never on out_ready_i.
   assign in_ready_o   = (state == RUN) && !full;
   assign out_valid_o  = !empty;
   assign out_data_o   = empty ? '0 : mem_data[rd_ptr];
   assign out_last_o   = !empty && mem_last[rd_ptr];
   assign line_done_o  = line_done;
   assign frame_done_o = (state == DONE);
   assign busy_o       = (state != IDLE);
   assign col_o        = col;
   assign row_o        = row;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = (width_i == '0 || height_i == '0) ? DONE : RUN;
         RUN:     if (push && beat_last) state_nxt = DRAIN;
         DRAIN:   if (pop && out_last_o) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clear_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         width_q   <= '0;
         height_q  <= '0;
         col       <= '0;
         row       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         line_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         line_done <= 1'b0;
         if (clear_i) begin
            col    <= '0;
            row    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (state == IDLE && start_i) begin
               width_q  <= width_i;
               height_q <= height_i;
               col      <= '0;
               row      <= '0;
            end
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
               // The final beat leaves col/row parked on the last position.
               if (col_end) begin
                  line_done <= 1'b1;
                  if (!row_end) begin
                     col <= '0;
                     row <= row + 32'd1;
                  end
               end else begin
                  col <= col + 32'd1;
               end
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !clear_i) begin
         mem_data[wr_ptr] <= in_data_i;
         mem_last[wr_ptr] <= beat_last;
      end
   end

endmodule

// File: tb/tb_conv_mdc_out_collector.sv
// Directed bench for conv_mdc_out_collector: scoreboarded frames, stall, empty frame,
// clear abort and asynchronous reset mid-drain.
module tb_conv_mdc_out_collector;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_i, clear_i, start_i;
   logic [31:0]   width_i, height_i;
   logic [DW-1:0] in_data_i;
   logic          in_valid_i, in_ready_o;
   logic [DW-1:0] out_data_o;
   logic          out_valid_o, out_ready_i, out_last_o;
   logic          line_done_o, frame_done_o, busy_o;
   logic [31:0]   col_o, row_o;

   conv_mdc_out_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
      .width_i(width_i), .height_i(height_i),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_last_o(out_last_o), .line_done_o(line_done_o), .frame_done_o(frame_done_o),
      .busy_o(busy_o), .col_o(col_o), .row_o(row_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int n_in, n_out, n_rdy, n_line, n_frame, n_last, fcyc, cyc, total, frame_id;
   logic          hold_pending;
   logic [DW-1:0] hold_data;
   logic [DW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  in_ready_o, 0);
      check({tag, "_out_valid"}, out_valid_o, 0);
      check({tag, "_out_last"},  out_last_o, 0);
      check({tag, "_out_data"},  out_data_o, 0);
      check({tag, "_line_done"}, line_done_o, 0);
      check({tag, "_frame_done"}, frame_done_o, 0);
      check({tag, "_busy"},      busy_o, 0);
      check({tag, "_col"},       col_o, 0);
      check({tag, "_row"},       row_o, 0);
   endtask

   task automatic new_frame(input int w, input int h);
      n_in = 0; n_out = 0; n_rdy = 0; n_line = 0; n_frame = 0; n_last = 0;
      fcyc = -1; cyc = 0; total = w * h; frame_id++;
      exp_q.delete();
      hold_pending = 1'b0;
   endtask

   // Sample at negedge, then return just after the next rising edge.
   task automatic tick();
      @(negedge clk_i);
      if (hold_pending) begin
         check("hold_valid", out_valid_o, 1);
         check("hold_data", out_data_o, hold_data);
      end
      if (out_valid_o && out_ready_i) begin
         n_out++;
         check("pop_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("data", out_data_o, exp_q.pop_front());
         check("last_tag", out_last_o, n_out == total);
         if (out_last_o) n_last++;
      end
      hold_pending = out_valid_o && !out_ready_i;
      hold_data    = out_data_o;
      if (in_valid_i && in_ready_o) begin
         exp_q.push_back(in_data_i);
         n_in++;
      end
      if (in_ready_o)   n_rdy++;
      if (line_done_o)  n_line++;
      if (frame_done_o) begin
         n_frame++;
         fcyc = cyc;
      end
      cyc++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_data();
      in_data_i = (DW'(frame_id) << 16) | DW'(n_in);
   endtask

   task automatic start_frame(input int w, input int h);
      new_frame(w, h);
      width_i = w; height_i = h; start_i = 1'b1;
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      drive_data();
      tick();
      start_i = 1'b0;
   endtask

   task automatic run_frame(input int w, input int h, input bit rnd, input int stall);
      start_frame(w, h);
      while (n_frame == 0 && cyc < 2000) begin
         if (stall != 0 && cyc == stall) begin
            check("stall_accepted", n_in, DEPTH);
            check("stall_in_ready", in_ready_o, 0);
            check("stall_out_valid", out_valid_o, 1);
         end
         drive_data();
         in_valid_i  = (n_in < total) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         out_ready_i = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         tick();
      end
      in_valid_i = 1'b0;
      check("frame_done_count", n_frame, 1);
      check("beats_in", n_in, total);
      check("beats_out", n_out, total);
      check("last_count", n_last, (total != 0) ? 1 : 0);
      check("line_done_count", n_line, (w == 0 || h == 0) ? 0 : h);
      check("queue_empty", exp_q.size(), 0);
      tick();
      check("busy_after", busy_o, 0);
      check("frame_done_single", n_frame, 1);
   endtask

   initial begin
      frame_id = 0;
      rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
      width_i = '0; height_i = '0; in_data_i = '0;
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      hold_pending = 1'b0; hold_data = '0;
      #12;
      check_all_zero("reset");
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // 4x2 streaming, ready always high
      run_frame(4, 2, 1'b0, 0);

      // 3x3 with the sink stalled for 10 cycles after start
      run_frame(3, 3, 1'b0, 11);

      // empty frame: width 0
      run_frame(0, 5, 1'b0, 0);
      check("zero_done_cycle", fcyc, 1);
      check("zero_never_ready", n_rdy, 0);

      // abort a 4x4 frame after 5 accepted beats
      start_frame(4, 4);
      out_ready_i = 1'b1;
      while (n_in < 5 && cyc < 100) begin
         drive_data();
         in_valid_i = 1'b1;
         tick();
      end
      check("clear_beats_in", n_in, 5);
      check("clear_col", col_o, 1);
      check("clear_row", row_o, 1);
      check("clear_busy_before", busy_o, 1);
      clear_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
      tick();
      clear_i = 1'b0;
      exp_q.delete();
      hold_pending = 1'b0;
      check("clear_busy", busy_o, 0);
      check("clear_out_valid", out_valid_o, 0);
      check("clear_col_zero", col_o, 0);
      check("clear_row_zero", row_o, 0);
      out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("clear_no_frame_done", n_frame, 0);
      run_frame(2, 2, 1'b0, 0);

      // random handshakes on 7x5
      run_frame(7, 5, 1'b1, 0);

      // 2x2 into a stalled sink reaches DRAIN with a full FIFO, then async reset
      start_frame(2, 2);
      for (int i = 0; i < 6; i++) begin
         drive_data();
         in_valid_i = (n_in < total);
         tick();
      end
      in_valid_i = 1'b0;
      check("drain_busy", busy_o, 1);
      check("drain_out_valid", out_valid_o, 1);
      check("drain_accepted", n_in, 4);
      check("drain_in_ready", in_ready_o, 0);
      #2;
      rst_i = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      exp_q.delete();
      hold_pending = 1'b0;
      @(posedge clk_i); #1;
      run_frame(2, 2, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
